// File: rtl/port_match_arbiter.sv
// Round-robin arbiter sharing one SRAM match engine among NUM_PORTS front-ends; PORT_MATCH_ARB_STATS_EN builds the stat counters.
// Latency: grant edge -> eng_start next cycle; eng_done in cycle k -> req_suc in k+1 -> IDLE in k+2.
// Backpressure: requesters hold req_enable until served; one engine op in flight, failed/timed-out ports retried on a later turn.
module port_match_arbiter #(
    parameter int NUM_PORTS = 16,
    parameter int SRAM_ID_W = 5,
    parameter int TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS-1:0]   req_enable,
    input  logic [NUM_PORTS*4-1:0] req_dest_port,
    input  logic [NUM_PORTS*9-1:0] req_length,
    output logic [NUM_PORTS-1:0]   req_suc,
    output logic [SRAM_ID_W-1:0]   req_sram_id,
    output logic                   eng_start,
    output logic [3:0]             eng_dest_port,
    output logic [8:0]             eng_length,
    input  logic                   eng_done,
    input  logic                   eng_fail,
    input  logic [SRAM_ID_W-1:0]   eng_sram_id,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [15:0]            stat_grants,
    output logic [15:0]            stat_fails
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       cur_port_q, cur_port_d;
    logic [3:0]             eng_dest_port_q, eng_dest_port_d;
    logic [8:0]             eng_length_q, eng_length_d;
    logic                   eng_start_q, eng_start_d;
    logic [7:0]             wait_cnt_q, wait_cnt_d;
    logic                   drop_q, drop_d;
    logic [NUM_PORTS-1:0]   req_suc_q, req_suc_d;
    logic [SRAM_ID_W-1:0]   req_sram_id_q, req_sram_id_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   busy_q, busy_d;

    logic                   grant_vld;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       scan_idx;

    // Rotating priority: first requester at or after rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        scan_idx  = rr_ptr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            scan_idx = rr_ptr_q + PTR_W'(i);
            if (!grant_vld && req_enable[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        cur_port_d      = cur_port_q;
        eng_dest_port_d = eng_dest_port_q;
        eng_length_d    = eng_length_q;
        eng_start_d     = 1'b0;
        wait_cnt_d      = wait_cnt_q;
        drop_d          = drop_q;
        req_suc_d       = '0;
        req_sram_id_d   = '0;
        timeout_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    state_d         = S_ISSUE;
                    cur_port_d      = grant_idx;
                    eng_dest_port_d = req_dest_port[4*int'(grant_idx) +: 4];
                    eng_length_d    = req_length[9*int'(grant_idx) +: 9];
                    eng_start_d     = 1'b1;
                    wait_cnt_d      = 8'd0;
                    drop_d          = 1'b0;
                end
            end
            S_ISSUE: begin
                state_d    = S_WAIT;
                wait_cnt_d = 8'd1;
                if (!req_enable[cur_port_q]) begin
                    drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (eng_done) begin
                    rr_ptr_d = cur_port_q + PTR_W'(1);
                    if (!eng_fail) begin
                        state_d = S_RESP;
                        // A requester that let go mid-op still completes but is not told.
                        if (!drop_q && req_enable[cur_port_q]) begin
                            req_suc_d[cur_port_q] = 1'b1;
                            req_sram_id_d         = eng_sram_id;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (wait_cnt_q == 8'(TIMEOUT)) begin
                    state_d       = S_IDLE;
                    rr_ptr_d      = cur_port_q + PTR_W'(1);
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (!req_enable[cur_port_q]) begin
                        drop_d = 1'b1;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            rr_ptr_q        <= '0;
            cur_port_q      <= '0;
            eng_dest_port_q <= '0;
            eng_length_q    <= '0;
            eng_start_q     <= 1'b0;
            wait_cnt_q      <= '0;
            drop_q          <= 1'b0;
            req_suc_q       <= '0;
            req_sram_id_q   <= '0;
            timeout_err_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            cur_port_q      <= cur_port_d;
            eng_dest_port_q <= eng_dest_port_d;
            eng_length_q    <= eng_length_d;
            eng_start_q     <= eng_start_d;
            wait_cnt_q      <= wait_cnt_d;
            drop_q          <= drop_d;
            req_suc_q       <= req_suc_d;
            req_sram_id_q   <= req_sram_id_d;
            timeout_err_q   <= timeout_err_d;
            busy_q          <= busy_d;
        end
    end

    assign req_suc       = req_suc_q;
    assign req_sram_id   = req_sram_id_q;
    assign eng_start     = eng_start_q;
    assign eng_dest_port = eng_dest_port_q;
    assign eng_length    = eng_length_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;

`ifdef PORT_MATCH_ARB_STATS_EN
    logic [15:0] stat_grants_q, stat_grants_d;
    logic [15:0] stat_fails_q, stat_fails_d;

    // Any WAIT->IDLE exit is either an engine fail or a timeout.
    always_comb begin
        stat_grants_d = stat_grants_q;
        stat_fails_d  = stat_fails_q;
        if ((req_suc_d != '0) && (stat_grants_q != 16'hFFFF)) begin
            stat_grants_d = stat_grants_q + 16'd1;
        end
        if ((state_q == S_WAIT) && (state_d == S_IDLE) && (stat_fails_q != 16'hFFFF)) begin
            stat_fails_d = stat_fails_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants_q <= '0;
            stat_fails_q  <= '0;
        end else begin
            stat_grants_q <= stat_grants_d;
            stat_fails_q  <= stat_fails_d;
        end
    end

    assign stat_grants = stat_grants_q;
    assign stat_fails  = stat_fails_q;
`else
    assign stat_grants = 16'h0;
    assign stat_fails  = 16'h0;
`endif

endmodule

// File: tb/tb_port_match_arbiter.sv
// Bench for port_match_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a transaction-level model of the arbiter.
module tb_port_match_arbiter;

    localparam int NP = 16;
    localparam int SW = 5;
    localparam int TO = 64;
`ifdef PORT_MATCH_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   req_enable = '0;
    logic [NP*4-1:0] req_dest_port = '0;
    logic [NP*9-1:0] req_length = '0;
    logic [NP-1:0]   req_suc;
    logic [SW-1:0]   req_sram_id;
    logic            eng_start;
    logic [3:0]      eng_dest_port;
    logic [8:0]      eng_length;
    logic            eng_done = 1'b0;
    logic            eng_fail = 1'b0;
    logic [SW-1:0]   eng_sram_id = '0;
    logic            busy;
    logic            timeout_err;
    logic [15:0]     stat_grants;
    logic [15:0]     stat_fails;

    always #5 clk = ~clk;

    port_match_arbiter #(.NUM_PORTS(NP), .SRAM_ID_W(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_enable(req_enable), .req_dest_port(req_dest_port), .req_length(req_length),
        .req_suc(req_suc), .req_sram_id(req_sram_id),
        .eng_start(eng_start), .eng_dest_port(eng_dest_port), .eng_length(eng_length),
        .eng_done(eng_done), .eng_fail(eng_fail), .eng_sram_id(eng_sram_id),
        .busy(busy), .timeout_err(timeout_err),
        .stat_grants(stat_grants), .stat_fails(stat_fails)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an op is "active" from grant until the engine answers or times out;
    // m_age counts cycles since grant (1 = start-pulse cycle, age-1 = WAIT count).
    bit          m_valid = 1'b0;
    bit          m_active = 1'b0;
    bit          m_resp = 1'b0;
    bit          m_drop = 1'b0;
    int          m_port = 0;
    int          m_age = 0;
    int          m_rr = 0;
    int          m_p = 0;
    int          m_grants = 0;
    int          m_fails = 0;
    logic [NP-1:0] e_suc = '0;
    logic [SW-1:0] e_sid = '0;
    logic [3:0]  e_dest = '0;
    logic [8:0]  e_len = '0;
    bit          e_start = 1'b0;
    bit          e_terr = 1'b0;
    bit          e_busy = 1'b0;

    always @(posedge clk) begin
        e_start = 1'b0;
        e_suc   = '0;
        e_sid   = '0;
        e_terr  = 1'b0;
        if (rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_resp   = 1'b0;
            m_drop   = 1'b0;
            m_rr     = 0;
            m_port   = 0;
            e_dest   = '0;
            e_len    = '0;
            m_grants = 0;
            m_fails  = 0;
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else if (!m_active) begin
            for (int i = 0; i < NP; i++) begin
                m_p = (m_rr + i) % NP;
                if (!m_active && req_enable[m_p]) begin
                    m_active = 1'b1;
                    m_port   = m_p;
                    m_age    = 1;
                    m_drop   = 1'b0;
                    e_start  = 1'b1;
                    e_dest   = req_dest_port[4*m_p +: 4];
                    e_len    = req_length[9*m_p +: 9];
                end
            end
        end else begin
            if (!req_enable[m_port]) m_drop = 1'b1;
            if (m_age >= 2 && eng_done) begin
                m_active = 1'b0;
                m_rr     = (m_port + 1) % NP;
                if (!eng_fail) begin
                    m_resp = 1'b1;
                    if (!m_drop) begin
                        e_suc[m_port] = 1'b1;
                        e_sid = eng_sram_id;
                        if (m_grants < 65535) m_grants++;
                    end
                end else if (m_fails < 65535) begin
                    m_fails++;
                end
            end else if (m_age - 1 == TO) begin
                m_active = 1'b0;
                m_rr     = (m_port + 1) % NP;
                e_terr   = 1'b1;
                if (m_fails < 65535) m_fails++;
            end else begin
                m_age++;
            end
        end
        e_busy = m_active || m_resp;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("req_suc", req_suc, e_suc);
            if (e_suc != '0) check("req_sram_id", req_sram_id, e_sid);
            check("eng_start", eng_start, e_start);
            check("eng_dest_port", eng_dest_port, e_dest);
            check("eng_length", eng_length, e_len);
            check("busy", busy, e_busy);
            check("timeout_err", timeout_err, e_terr);
            check("stat_grants", stat_grants, STATS ? m_grants : 0);
            check("stat_fails", stat_fails, STATS ? m_fails : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!eng_start && n < 300) begin
            tick();
            n++;
        end
        if (!eng_start) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_start: no eng_start within %0d cycles", n);
        end
    endtask

    // Answer the current op successfully after 'delay' cycles, expect the pulse, then release the port.
    task automatic complete_ok(input int delay, input int port, input string name);
        repeat (delay) tick();
        eng_done    = 1'b1;
        eng_fail    = 1'b0;
        eng_sram_id = SW'(port + 3);
        tick();
        eng_done = 1'b0;
        check(name, req_suc, 32'(1) << port);
        check({name, "_sid"}, req_sram_id, port + 3);
        tick();
        req_enable[port] = 1'b0;
    endtask

    int n;
    int pulses;
    int cd;
    logic [NP-1:0] dropnext;

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_req_suc", req_suc, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_busy", busy, 0);
        check("rst_dest", eng_dest_port, 0);
        check("rst_len", eng_length, 0);
        check("rst_stat_grants", stat_grants, 0);
        rst = 1'b0;

        // Single request, engine answers 5 cycles after start
        req_dest_port[3:0] = 4'h3;
        req_length[8:0]    = 9'd40;
        req_enable         = 16'h0001;
        wait_start(n);
        check("t1_start_cycle", n, 1);
        check("t1_dest", eng_dest_port, 3);
        check("t1_len", eng_length, 40);
        repeat (5) tick();
        eng_done    = 1'b1;
        eng_sram_id = 5'd7;
        tick();
        eng_done = 1'b0;
        check("t1_suc", req_suc, 16'h0001);
        check("t1_sid", req_sram_id, 7);
        check("t1_busy_resp", busy, 1);
        tick();
        req_enable = '0;
        check("t1_busy_after", busy, 0);
        check("t1_suc_after", req_suc, 0);

        // Round-robin order with wrap-around
        do_reset();
        for (int i = 0; i < NP; i++) begin
            req_dest_port[4*i +: 4] = 4'(i);
            req_length[9*i +: 9]    = 9'(i * 7 + 3);
        end
        req_enable = 16'h8003;
        wait_start(n);
        check("t2_grant_a", eng_dest_port, 0);
        complete_ok(3, 0, "t2_suc_a");
        wait_start(n);
        check("t2_grant_b", eng_dest_port, 1);
        complete_ok(2, 1, "t2_suc_b");
        req_enable[0] = 1'b1;
        wait_start(n);
        check("t2_grant_c", eng_dest_port, 15);
        check("t2_len_c", eng_length, 15 * 7 + 3);
        complete_ok(4, 15, "t2_suc_c");
        wait_start(n);
        check("t2_grant_wrap", eng_dest_port, 0);
        complete_ok(1, 0, "t2_suc_wrap");

        // Engine fail: no pulse, immediate retry
        do_reset();
        req_enable = 16'h0004;
        wait_start(n);
        check("t3_grant", eng_dest_port, 2);
        repeat (2) tick();
        eng_done = 1'b1;
        eng_fail = 1'b1;
        tick();
        eng_done = 1'b0;
        eng_fail = 1'b0;
        check("t3_no_suc", req_suc, 0);
        check("t3_busy", busy, 0);
        check("t3_stat_fails", stat_fails, STATS ? 1 : 0);
        tick();
        check("t3_regrant", eng_start, 1);
        check("t3_regrant_dest", eng_dest_port, 2);
        complete_ok(2, 2, "t3_suc");

        // Timeout after TO silent WAIT cycles, late done in IDLE ignored
        do_reset();
        req_enable = 16'h0020;
        wait_start(n);
        pulses = 0;
        for (int c = 1; c <= TO; c++) begin
            tick();
            if (timeout_err) pulses++;
        end
        check("t4_busy_last_wait", busy, 1);
        check("t4_early_pulses", pulses, 0);
        tick();
        check("t4_timeout_err", timeout_err, 1);
        check("t4_busy_idle", busy, 0);
        eng_done    = 1'b1;
        eng_sram_id = 5'd21;
        tick();
        eng_done = 1'b0;
        check("t4_late_done_suc", req_suc, 0);
        check("t4_retry", eng_start, 1);
        check("t4_timeout_once", timeout_err, 0);
        complete_ok(3, 5, "t4_suc");

        // Requester drops mid-op, then reset mid-WAIT
        do_reset();
        req_enable = 16'h0010;
        wait_start(n);
        tick();
        req_enable[4] = 1'b0;
        tick();
        eng_done    = 1'b1;
        eng_sram_id = 5'd9;
        tick();
        eng_done = 1'b0;
        check("t5_suppressed", req_suc, 0);
        check("t5_busy_resp", busy, 1);
        check("t5_stat_grants", stat_grants, 0);
        tick();
        check("t5_busy_idle", busy, 0);
        req_enable[4] = 1'b1;
        wait_start(n);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_enable = '0;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_start", eng_start, 0);
        check("t5_rst_dest", eng_dest_port, 0);
        check("t5_rst_len", eng_length, 0);
        check("t5_rst_suc", req_suc, 0);

        // Randomized traffic against the model
        do_reset();
        cd       = 0;
        dropnext = '0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            eng_done = 1'b0;
            eng_fail = 1'b0;
            rst = ($urandom % 1500 == 0);
            for (int i = 0; i < NP; i++) begin
                if (dropnext[i]) begin
                    req_enable[i] = 1'b0;
                    dropnext[i]   = 1'b0;
                end else if (!req_enable[i] && ($urandom % 8 == 0)) begin
                    req_enable[i] = 1'b1;
                end else if (req_enable[i] && ($urandom % 400 == 0)) begin
                    req_enable[i] = 1'b0;
                end
                if (req_suc[i]) dropnext[i] = 1'b1;
                req_dest_port[4*i +: 4] = 4'($urandom);
                req_length[9*i +: 9]    = 9'($urandom);
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    eng_done    = 1'b1;
                    eng_fail    = ($urandom % 4 == 0);
                    eng_sram_id = SW'($urandom);
                end
            end else if ($urandom % 80 == 0) begin
                eng_done    = 1'b1;
                eng_fail    = ($urandom % 2 == 0);
                eng_sram_id = SW'($urandom);
            end
            if (eng_start) cd = ($urandom % 16 == 0) ? $urandom_range(60, 70) : $urandom_range(1, 8);
        end
        rst      = 1'b0;
        eng_done = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
